// File: rtl/iotdf_pkg.sv
// Shared constants, feeder state enum and byte-select helper for the IOTDF byte feeder.
package iotdf_pkg;

  localparam int WORD_W         = 128;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 16;
  localparam int IDX_W          = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } feeder_state_e;

  // Byte i of a word, LSB byte first.
  function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                  input logic [IDX_W-1:0]  i);
    return w[{i, 3'b000} +: BYTE_W];
  endfunction

endpackage

// File: rtl/iotdf_word_fifo.sv
// Show-ahead word FIFO: dout always presents the head entry while not empty.
module iotdf_word_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage needs no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/iotdf_byte_feeder.sv
// Buffers 128-bit words and feeds them byte-by-byte (LSB first) to the IOTDF.
// Optional words_sent counter is enabled with `define IOTDF_FEED_CNT_EN.
module iotdf_byte_feeder
  import iotdf_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_in,
  output logic              word_ready,
  input  logic              busy,
  output logic              in_en,
  output logic [BYTE_W-1:0] iot_in,
`ifdef IOTDF_FEED_CNT_EN
  output logic [7:0]        words_sent,
`endif
  output feeder_state_e     dbg_state
);

  // Handshake: a word transfers on a rising edge where word_valid && word_ready.
  // word_ready is !full only, so a full FIFO refuses even when popping that edge.

  feeder_state_e     state;
  logic [WORD_W-1:0] cur_word;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              last_byte;

  assign word_ready = !fifo_full;
  assign push       = word_valid && word_ready;
  assign last_byte  = (state == ST_SEND) && !busy && (idx == IDX_W'(BYTES_PER_WORD - 1));
  assign pop        = !fifo_empty && ((state == ST_IDLE) || last_byte);
  assign dbg_state  = state;

  iotdf_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (word_in),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cur_word <= '0;
      idx      <= '0;
      in_en    <= 1'b0;
      iot_in   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          in_en  <= 1'b0;
          iot_in <= '0;
          if (!fifo_empty) begin
            cur_word <= fifo_head;
            idx      <= '0;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (busy) begin
            in_en  <= 1'b0;
            iot_in <= '0;
          end else begin
            in_en  <= 1'b1;
            iot_in <= word_byte(cur_word, idx);
            if (last_byte) begin
              // Chain straight into the next word when one is waiting.
              idx <= '0;
              if (!fifo_empty) begin
                cur_word <= fifo_head;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          idx    <= '0;
          in_en  <= 1'b0;
          iot_in <= '0;
        end
      endcase
    end
  end

`ifdef IOTDF_FEED_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      words_sent <= '0;
    end else if (last_byte) begin
      words_sent <= words_sent + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_iotdf_byte_feeder.sv
// Directed self-checking bench for iotdf_byte_feeder (FIFO_DEPTH=2).
module tb_iotdf_byte_feeder;
  import iotdf_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          word_valid;
  logic [127:0]  word_in;
  logic          word_ready;
  logic          busy;
  logic          in_en;
  logic [7:0]    iot_in;
  feeder_state_e dbg_state;
`ifdef IOTDF_FEED_CNT_EN
  logic [7:0]    words_sent;
`endif

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  iotdf_byte_feeder #(.FIFO_DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .word_valid (word_valid),
    .word_in    (word_in),
    .word_ready (word_ready),
    .busy       (busy),
    .in_en      (in_en),
    .iot_in     (iot_in),
`ifdef IOTDF_FEED_CNT_EN
    .words_sent (words_sent),
`endif
    .dbg_state  (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #800000;
    failures = failures + 1;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load_word(input logic [127:0] w);
    for (int j = 0; j < 16; j++) exp_q.push_back(w[j*8 +: 8]);
  endtask

  task automatic drain_expect(input int n, input string tag);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check({tag, "_en"}, in_en, 1'b1);
      check({tag, "_byte"}, iot_in, e);
    end
  endtask

  task automatic expect_idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_en"}, in_en, 1'b0);
      check({tag, "_byte"}, iot_in, 8'h00);
    end
  endtask

  task automatic offer(input logic [127:0] w);
    @(negedge clk);
    word_valid = 1'b1;
    word_in    = w;
    @(posedge clk);
    #1 word_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    word_valid = 1'b0;
    word_in    = '0;
    busy       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_en", in_en, 1'b0);
    check("rst_byte", iot_in, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    check("rel_ready", word_ready, 1'b1);
    check("rel_state", dbg_state, ST_IDLE);
    check("rel_en", in_en, 1'b0);
`ifdef IOTDF_FEED_CNT_EN
    check("cnt_rst", words_sent, 8'd0);
`endif

    // single word: first byte two edges after acceptance
    offer(128'h0F0E0D0C0B0A09080706050403020100);
    load_word(128'h0F0E0D0C0B0A09080706050403020100);
    expect_idle(2, "t1_lat");
    drain_expect(16, "t1");
    expect_idle(1, "t1_end");

    // busy stall at byte 05
    offer(128'hAF_AE_AD_AC_AB_AA_A9_A8_A7_A6_A5_A4_A3_A2_A1_A0);
    load_word(128'hAF_AE_AD_AC_AB_AA_A9_A8_A7_A6_A5_A4_A3_A2_A1_A0);
    expect_idle(2, "t2_lat");
    drain_expect(5, "t2_pre");
    busy = 1'b1;
    expect_idle(3, "t2_stall");
    busy = 1'b0;
    drain_expect(11, "t2_post");
    expect_idle(1, "t2_end");

    // back-to-back words on consecutive edges
    @(negedge clk);
    word_valid = 1'b1;
    word_in    = 128'h1F1E1D1C1B1A19181716151413121110;
    @(posedge clk);
    #1 word_in = 128'h2F2E2D2C2B2A29282726252423222120;
    @(posedge clk);
    #1 word_valid = 1'b0;
    load_word(128'h1F1E1D1C1B1A19181716151413121110);
    load_word(128'h2F2E2D2C2B2A29282726252423222120);
    expect_idle(1, "t3_lat");
    drain_expect(32, "t3");
    expect_idle(1, "t3_end");

    // backpressure with busy held high
    busy = 1'b1;
    @(negedge clk);
    word_valid = 1'b1;
    word_in    = 128'hC0C0C0C0C0C0C0C0C0C0C0C0C0C0C0C0;
    check("bp_rdy0", word_ready, 1'b1);
    @(negedge clk);
    word_in = 128'hC1C1C1C1C1C1C1C1C1C1C1C1C1C1C1C1;
    check("bp_rdy1", word_ready, 1'b1);
    @(negedge clk);
    word_in = 128'hC2C2C2C2C2C2C2C2C2C2C2C2C2C2C2C2;
    check("bp_rdy2", word_ready, 1'b1);
    @(negedge clk);
    word_in = 128'hC3C3C3C3C3C3C3C3C3C3C3C3C3C3C3C3;
    check("bp_full", word_ready, 1'b0);
    check("bp_stall_en", in_en, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bp_full_hold", word_ready, 1'b0);
    end
    word_valid = 1'b0;
    busy       = 1'b0;
    load_word(128'hC0C0C0C0C0C0C0C0C0C0C0C0C0C0C0C0);
    load_word(128'hC1C1C1C1C1C1C1C1C1C1C1C1C1C1C1C1);
    load_word(128'hC2C2C2C2C2C2C2C2C2C2C2C2C2C2C2C2);
    drain_expect(48, "t4");
    expect_idle(1, "t4_end");
    check("bp_ready_after", word_ready, 1'b1);
`ifdef IOTDF_FEED_CNT_EN
    check("cnt_7", words_sent, 8'd7);
`endif

    // reset mid-word after byte 07
    offer(128'h5F5E5D5C5B5A59585756555453525150);
    load_word(128'h5F5E5D5C5B5A59585756555453525150);
    expect_idle(2, "t5_lat");
    drain_expect(8, "t5_pre");
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_en", in_en, 1'b0);
    check("t5_rst_byte", iot_in, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    check("t5_ready", word_ready, 1'b1);
    check("t5_state", dbg_state, ST_IDLE);
    expect_idle(20, "t5_nobyte");
`ifdef IOTDF_FEED_CNT_EN
    check("cnt_rst_mid", words_sent, 8'd0);
    begin
      int n;
      int k;
      logic rdy;
      n = 0;
      k = 0;
      while (n < 257 && k < 10000) begin
        @(negedge clk);
        rdy        = word_ready;
        word_valid = 1'b1;
        word_in    = {96'h0, 32'(n)};
        @(posedge clk);
        if (rdy) n = n + 1;
        k = k + 1;
      end
      #1 word_valid = 1'b0;
      check("cnt_push_bound", n, 257);
      repeat (80) @(negedge clk);
      check("cnt_wrap", words_sent, 8'd1);
      check("cnt_idle", in_en, 1'b0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
